pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage RV32 pipeline. Shadows the EX/MEM/WB occupancy, including each stage's destination register and instruction class. From that state it drives IF/ID stall, ID flush, EX bubble insertion and EX operand-forwarding selects. It sits beside `pipeline_decode`, consuming its opcode/rs1/rs2/rd outputs, and also counts stall cycles for performance monitoring.

---
 rtl/pipeline_hazard_ctrl.sv | 93 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/bubble/forwarding control for a five-stage RV32 pipeline
// Ports: clk_i/rst_n_i clock and async active-low reset; id_* decoded ID-stage instruction;
//   ex_redirect_i taken control transfer in EX; mem_ready_i MEM access completes;
//   if/id/mem stall, id flush and ex bubble controls; fwd_a/b_sel_o EX operand sources
//   (00 regfile, 01 MEM, 10 WB); stall_cnt_o saturating stall-cycle count.
module pipeline_hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   id_valid_i,
  input  logic [6:0]             id_opcode_i,
  input  logic [4:0]             id_rs1_i,
  input  logic [4:0]             id_rs2_i,
  input  logic [4:0]             id_rd_i,
  input  logic                   ex_redirect_i,
  input  logic                   mem_ready_i,
  output logic                   if_stall_o,
  output logic                   id_stall_o,
  output logic                   id_flush_o,
  output logic                   ex_bubble_o,
  output logic                   mem_stall_o,
  output logic [1:0]             fwd_a_sel_o,
  output logic [1:0]             fwd_b_sel_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  logic uses_rs1, uses_rs2, writes_rd, is_load, is_mem;
  logic ex_v, ex_wr, ex_ld, ex_mem;
  logic [4:0] ex_rd, ex_rs1, ex_rs2;
  logic mem_v, mem_wr, mem_ld, mem_mem;
  logic [4:0] mem_rd;
  logic wb_v, wb_wr;
  logic [4:0] wb_rd;
  logic ex_src, mem_fwd, wb_src;
  logic mem_stall, redirect, load_use;
  assign uses_rs1  = !(id_opcode_i inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign uses_rs2  = id_opcode_i inside {OP_RTYPE, OP_STORE, OP_BRANCH};
  assign writes_rd = !(id_opcode_i inside {OP_STORE, OP_BRANCH});
  assign is_load   = id_opcode_i == OP_LOAD;
  assign is_mem    = is_load | (id_opcode_i == OP_STORE);
  // x0 is never a hazard source; a load in MEM has no result yet, so it cannot forward from MEM
  assign ex_src  = ex_v & ex_wr & (ex_rd != 5'd0);
  assign mem_fwd = mem_v & mem_wr & (mem_rd != 5'd0) & ~mem_ld;
  assign wb_src  = wb_v & wb_wr & (wb_rd != 5'd0);
  assign mem_stall = mem_v & mem_mem & ~mem_ready_i;
  assign redirect  = ~mem_stall & ex_redirect_i;
  assign load_use  = ~mem_stall & ~redirect & id_valid_i & ex_src & ex_ld &
                     ((uses_rs1 & (ex_rd == id_rs1_i)) | (uses_rs2 & (ex_rd == id_rs2_i)));
  assign if_stall_o  = mem_stall | load_use;
  assign id_stall_o  = mem_stall | load_use;
  assign id_flush_o  = redirect;
  assign ex_bubble_o = redirect | load_use;
  assign mem_stall_o = mem_stall;
  assign fwd_a_sel_o = !ex_v ? 2'b00 : (mem_fwd & (mem_rd == ex_rs1)) ? 2'b01 :
                       (wb_src & (wb_rd == ex_rs1)) ? 2'b10 : 2'b00;
  assign fwd_b_sel_o = !ex_v ? 2'b00 : (mem_fwd & (mem_rd == ex_rs2)) ? 2'b01 :
                       (wb_src & (wb_rd == ex_rs2)) ? 2'b10 : 2'b00;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_v <= 1'b0; ex_wr <= 1'b0; ex_ld <= 1'b0; ex_mem <= 1'b0;
      ex_rd <= '0; ex_rs1 <= '0; ex_rs2 <= '0;
      mem_v <= 1'b0; mem_wr <= 1'b0; mem_ld <= 1'b0; mem_mem <= 1'b0; mem_rd <= '0;
      wb_v <= 1'b0; wb_wr <= 1'b0; wb_rd <= '0;
    end else if (!mem_stall) begin
      wb_v    <= mem_v;
      wb_wr   <= mem_wr;
      wb_rd   <= mem_rd;
      mem_v   <= ex_v;
      mem_wr  <= ex_wr;
      mem_ld  <= ex_ld;
      mem_mem <= ex_mem;
      mem_rd  <= ex_rd;
      ex_v    <= id_valid_i & ~ex_bubble_o;
      ex_wr   <= writes_rd;
      ex_ld   <= is_load;
      ex_mem  <= is_mem;
      ex_rd   <= id_rd_i;
      ex_rs1  <= id_rs1_i;
      ex_rs2  <= id_rs2_i;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stall_cnt_o <= '0;
    else if (if_stall_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam logic [6:0] LW = 7'b0000011, ADD = 7'b0110011, ADDI = 7'b0010011, SW = 7'b0100011;
  logic clk = 1'b0, rst_n_i = 1'b0;
  logic id_valid_i = 1'b0, ex_redirect_i = 1'b0, mem_ready_i = 1'b1;
  logic [6:0] id_opcode_i = '0;
  logic [4:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
  logic if_stall_o, id_stall_o, id_flush_o, ex_bubble_o, mem_stall_o;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
  logic [3:0] stall_cnt_o;
  logic [12:0] sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.STALL_CNT_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .ex_redirect_i(ex_redirect_i),
    .mem_ready_i(mem_ready_i), .if_stall_o(if_stall_o), .id_stall_o(id_stall_o),
    .id_flush_o(id_flush_o), .ex_bubble_o(ex_bubble_o), .mem_stall_o(mem_stall_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o), .stall_cnt_o(stall_cnt_o));
  // expected vector: {if_stall, id_stall, id_flush, ex_bubble, mem_stall, fwd_a, fwd_b, cnt}
  function automatic logic [12:0] pk(logic ifs, logic ids, logic fl, logic bu, logic ms,
                                     logic [1:0] fa, logic [1:0] fb, logic [3:0] c);
    return {ifs, ids, fl, bu, ms, fa, fb, c};
  endfunction
  task automatic drive(logic v, logic [6:0] op, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                       logic redir, logic rdy, logic [12:0] e);
    id_valid_i = v; id_opcode_i = op; id_rs1_i = r1; id_rs2_i = r2; id_rd_i = rd;
    ex_redirect_i = redir; mem_ready_i = rdy;
    sb.push_back(e);
  endtask
  task automatic check(string tag);
    logic [12:0] got, exp;
    got = {if_stall_o, id_stall_o, id_flush_o, ex_bubble_o, mem_stall_o, fwd_a_sel_o, fwd_b_sel_o, stall_cnt_o};
    exp = sb.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic step(string tag, logic v, logic [6:0] op, logic [4:0] r1, logic [4:0] r2,
                      logic [4:0] rd, logic redir, logic rdy, logic [12:0] e);
    drive(v, op, r1, r2, rd, redir, rdy, e);
    #2;
    check(tag);
    @(posedge clk);
    #1;
  endtask
  initial begin
    step("reset", 0, ADD, 0, 0, 0, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd0));
    rst_n_i = 1'b1;
    step("lw_x5", 1, LW, 2, 0, 5, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd0));
    step("load_use", 1, ADD, 5, 1, 6, 0, 1, pk(1,1,0,1,0,2'b00,2'b00,4'd0));
    step("lu_release", 1, ADD, 5, 1, 6, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd1));
    step("lu_fwd_wb", 0, ADD, 0, 0, 0, 0, 1, pk(0,0,0,0,0,2'b10,2'b00,4'd1));
    step("addi_x3", 1, ADDI, 0, 1, 3, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd1));
    step("alu_dep_nostall", 1, ADD, 3, 3, 4, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd1));
    step("alu_fwd_mem", 0, ADD, 0, 0, 0, 0, 1, pk(0,0,0,0,0,2'b01,2'b01,4'd1));
    step("lw_x0", 1, LW, 2, 0, 0, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd1));
    step("x0_nostall", 1, ADD, 0, 0, 1, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd1));
    step("x0_nofwd", 0, ADD, 0, 0, 0, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd1));
    step("lw_x7", 1, LW, 2, 0, 7, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd1));
    step("redir_over_lu", 1, ADD, 7, 7, 8, 1, 1, pk(0,0,1,1,0,2'b00,2'b00,4'd1));
    step("redir_cnt_same", 0, ADD, 0, 0, 0, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd1));
    step("sw_id", 1, SW, 2, 9, 4, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd1));
    step("sw_ex", 0, ADD, 0, 0, 0, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd1));
    for (int i = 0; i < 3; i++)
      step($sformatf("mem_wait_%0d", i), 0, ADD, 0, 0, 0, 1, 0, pk(1,1,0,0,1,2'b00,2'b00,4'(1 + i)));
    step("mem_ready_flush", 0, ADD, 0, 0, 0, 1, 1, pk(0,0,1,1,0,2'b00,2'b00,4'd4));
    step("sw2_id", 1, SW, 2, 9, 4, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd4));
    step("sw2_ex", 0, ADD, 0, 0, 0, 0, 1, pk(0,0,0,0,0,2'b00,2'b00,4'd4));
    for (int i = 0; i < 20; i++)
      step($sformatf("sat_%0d", i), 0, ADD, 0, 0, 0, 0, 0,
           pk(1,1,0,0,1,2'b00,2'b00,(4 + i > 15) ? 4'd15 : 4'(4 + i)));
    drive(0, ADD, 0, 0, 0, 0, 0, pk(1,1,0,0,1,2'b00,2'b00,4'd15));
    #2;
    check("sat_hold");
    rst_n_i = 1'b0;
    drive(0, ADD, 0, 0, 0, 0, 0, pk(0,0,0,0,0,2'b00,2'b00,4'd0));
    #1;
    check("async_rst");
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    step("post_rst_empty", 0, ADD, 0, 0, 0, 0, 0, pk(0,0,0,0,0,2'b00,2'b00,4'd0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
